// File: rtl/boreal_policy_vm.sv
// Policy VM: runs a loaded micro-ISA program over a channel snapshot and commits IK targets atomically.
// Latency: a start at edge E0 with N executed instructions strobes vm_ik_enable after edge E0+N.
// Backpressure: none; data_valid while busy is dropped (overrun), prog_we while busy is rejected (prog_err).
module boreal_policy_vm #(
   parameter int DATA_W     = 16,
   parameter int NCH        = 4,
   parameter int PROG_DEPTH = 256,
   parameter int STEP_LIMIT = 128,
   localparam int ADDR_W    = $clog2(PROG_DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [1:0]               safety_tier,
   input  logic                     data_valid,
   input  logic [NCH*DATA_W-1:0]    mu_in,
   input  logic                     prog_we,
   input  logic [ADDR_W-1:0]        prog_addr,
   input  logic [31:0]              prog_wdata,
   input  logic                     fault_clr,
   output logic signed [DATA_W-1:0] target_x,
   output logic signed [DATA_W-1:0] target_y,
   output logic                     vm_ik_enable,
   output logic                     vm_vns_override,
   output logic                     busy,
   output logic                     vm_abort,
   output logic                     vm_fault,
   output logic                     overrun,
   output logic                     prog_err
);

   localparam int STEP_W = $clog2(STEP_LIMIT + 1);

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_CMP  = 4'h1;
   localparam logic [3:0] OP_JLT  = 4'h2;
   localparam logic [3:0] OP_JGT  = 4'h3;
   localparam logic [3:0] OP_SETX = 4'h4;
   localparam logic [3:0] OP_SETY = 4'h5;
   localparam logic [3:0] OP_JEQ  = 4'h6;
   localparam logic [3:0] OP_JMP  = 4'h7;
   localparam logic [3:0] OP_HALT = 4'hE;
   localparam logic [3:0] OP_VNS  = 4'hF;

   typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_t;

   state_t                    state_q;
   logic [ADDR_W-1:0]         pc_q;
   logic [ADDR_W-1:0]         pc_d;
   logic [STEP_W-1:0]         steps_q;
   logic                      lt_q, gt_q, eq_q;
   logic signed [DATA_W-1:0]  shx_q, shy_q;
   logic signed [DATA_W-1:0]  tgt_x_q, tgt_y_q;
   logic signed [DATA_W-1:0]  snap_q [NCH];
   logic                      ik_q, vns_q, busy_q, abort_q, fault_q, overrun_q, prog_err_q;

   // Program store has no reset so a loaded policy survives a reset pulse.
   logic [31:0]               prog_mem [PROG_DEPTH];

   logic [31:0]               instr;
   logic [3:0]                opc;
   logic [3:0]                ch;
   logic signed [DATA_W-1:0]  imm;
   logic [ADDR_W-1:0]         jtgt;
   logic [ADDR_W-1:0]         pc_inc;
   logic signed [DATA_W-1:0]  ch_val;
   logic                      ch_ok;
   logic                      illegal;
   logic                      unused_ok;

   assign instr     = prog_mem[pc_q];
   assign opc       = instr[31:28];
   assign ch        = instr[27:24];
   assign imm       = instr[DATA_W-1:0];
   assign jtgt      = instr[ADDR_W-1:0];
   assign pc_inc    = pc_q + ADDR_W'(1);
   assign ch_ok     = (int'(ch) < NCH);
   assign unused_ok = ^instr[23:16];

   // Program writes are accepted only while the VM is idle.
   always_ff @(posedge clk) begin
      if (prog_we && (state_q == ST_IDLE)) begin
         prog_mem[prog_addr] <= prog_wdata;
      end
   end

   // Select the snapshot channel addressed by the current instruction.
   always_comb begin
      ch_val = '0;
      for (int k = 0; k < NCH; k++) begin
         if (ch == 4'(k)) begin
            ch_val = snap_q[k];
         end
      end
   end

   // Flag unassigned opcodes and CMP against a channel that does not exist.
   always_comb begin
      illegal = 1'b0;
      case (opc)
         OP_NOP, OP_JLT, OP_JGT, OP_SETX, OP_SETY,
         OP_JEQ, OP_JMP, OP_HALT, OP_VNS: illegal = 1'b0;
         OP_CMP:                          illegal = !ch_ok;
         default:                         illegal = 1'b1;
      endcase
   end

   // Next program counter; sequential flow wraps at the end of the program store.
   always_comb begin
      pc_d = pc_inc;
      case (opc)
         OP_JLT:  pc_d = lt_q ? jtgt : pc_inc;
         OP_JGT:  pc_d = gt_q ? jtgt : pc_inc;
         OP_JEQ:  pc_d = eq_q ? jtgt : pc_inc;
         OP_JMP:  pc_d = jtgt;
         default: pc_d = pc_inc;
      endcase
   end

   // Control FSM with registered outputs; abort beats fault beats commit beats watchdog.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         pc_q       <= '0;
         steps_q    <= '0;
         lt_q       <= 1'b0;
         gt_q       <= 1'b0;
         eq_q       <= 1'b0;
         shx_q      <= '0;
         shy_q      <= '0;
         tgt_x_q    <= '0;
         tgt_y_q    <= '0;
         for (int k = 0; k < NCH; k++) snap_q[k] <= '0;
         ik_q       <= 1'b0;
         vns_q      <= 1'b0;
         busy_q     <= 1'b0;
         abort_q    <= 1'b0;
         fault_q    <= 1'b0;
         overrun_q  <= 1'b0;
         prog_err_q <= 1'b0;
      end else begin
         ik_q       <= 1'b0;
         abort_q    <= 1'b0;
         overrun_q  <= 1'b0;
         prog_err_q <= prog_we && (state_q != ST_IDLE);
         case (state_q)
            ST_IDLE: begin
               if (fault_clr) begin
                  fault_q <= 1'b0;
               end else if (data_valid && !safety_tier[1] && !fault_q) begin
                  for (int k = 0; k < NCH; k++) snap_q[k] <= mu_in[k*DATA_W +: DATA_W];
                  pc_q    <= '0;
                  steps_q <= '0;
                  lt_q    <= 1'b0;
                  gt_q    <= 1'b0;
                  eq_q    <= 1'b0;
                  shx_q   <= tgt_x_q;
                  shy_q   <= tgt_y_q;
                  vns_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               overrun_q <= data_valid;
               if (safety_tier[1]) begin
                  abort_q <= 1'b1;
                  vns_q   <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else if (illegal) begin
                  fault_q <= 1'b1;
                  vns_q   <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else if (opc == OP_HALT) begin
                  tgt_x_q <= shx_q;
                  tgt_y_q <= shy_q;
                  ik_q    <= 1'b1;
                  state_q <= ST_DONE;
               end else if (steps_q == STEP_W'(STEP_LIMIT - 1)) begin
                  fault_q <= 1'b1;
                  vns_q   <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else begin
                  pc_q    <= pc_d;
                  steps_q <= steps_q + STEP_W'(1);
                  case (opc)
                     OP_CMP: begin
                        lt_q <= (ch_val < imm);
                        gt_q <= (ch_val > imm);
                        eq_q <= (ch_val == imm);
                     end
                     OP_SETX: shx_q <= imm;
                     OP_SETY: shy_q <= imm;
                     OP_VNS:  vns_q <= 1'b1;
                     default: ;
                  endcase
               end
            end
            ST_DONE: begin
               overrun_q <= data_valid;
               busy_q    <= 1'b0;
               state_q   <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign target_x        = tgt_x_q;
   assign target_y        = tgt_y_q;
   assign vm_ik_enable    = ik_q;
   assign vm_vns_override = vns_q;
   assign busy            = busy_q;
   assign vm_abort        = abort_q;
   assign vm_fault        = fault_q;
   assign overrun         = overrun_q;
   assign prog_err        = prog_err_q;

endmodule

// File: tb/tb_boreal_policy_vm.sv
// Directed bench for boreal_policy_vm with hand-computed expectations.
// Inputs are driven and outputs sampled on the falling edge; DUT acts on the rising edge.
// Every wait on the DUT is bounded; an expired bound shows up as a latency miscompare.
module tb_boreal_policy_vm;

   logic        clk;
   logic        rst_n;
   logic [1:0]  safety_tier;
   logic        data_valid;
   logic [63:0] mu_in;
   logic        prog_we;
   logic [7:0]  prog_addr;
   logic [31:0] prog_wdata;
   logic        fault_clr;
   logic signed [15:0] target_x, target_y;
   logic        vm_ik_enable, vm_vns_override, busy, vm_abort, vm_fault, overrun, prog_err;

   int n_vec = 0;
   int n_err = 0;

   boreal_policy_vm #(.DATA_W(16), .NCH(4), .PROG_DEPTH(256), .STEP_LIMIT(128)) dut (
      .clk(clk), .rst_n(rst_n), .safety_tier(safety_tier), .data_valid(data_valid),
      .mu_in(mu_in), .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
      .fault_clr(fault_clr), .target_x(target_x), .target_y(target_y),
      .vm_ik_enable(vm_ik_enable), .vm_vns_override(vm_vns_override), .busy(busy),
      .vm_abort(vm_abort), .vm_fault(vm_fault), .overrun(overrun), .prog_err(prog_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ins(input logic [3:0] op, input logic [3:0] c, input logic [15:0] imm);
      return {op, c, 8'h00, imm};
   endfunction

   function automatic logic [63:0] mu_ch0(input logic [15:0] v);
      return {48'd0, v};
   endfunction

   task automatic wr(input logic [7:0] a, input logic [31:0] w);
      @(negedge clk);
      prog_we = 1'b1; prog_addr = a; prog_wdata = w;
      @(negedge clk);
      prog_we = 1'b0;
   endtask

   // Returns at the falling edge just after the start edge E0.
   task automatic start_eval(input logic [63:0] mu);
      @(negedge clk);
      mu_in = mu; data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
   endtask

   // Counts falling edges after E0 until commit, abort or fault; -1 if none.
   task automatic wait_evt(output int lat);
      lat = -1;
      for (int c = 1; c <= 300; c++) begin
         @(negedge clk);
         if (vm_ik_enable || vm_abort || vm_fault) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic run(input string tag, input logic [63:0] mu, input int exp_lat,
                      input logic [15:0] ex, input logic [15:0] ey);
      int lat;
      start_eval(mu);
      wait_evt(lat);
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_ik"}, 32'(vm_ik_enable), 32'd1);
      chk({tag, "_busy_done"}, 32'(busy), 32'd1);
      chk({tag, "_tx"}, 32'(target_x), {16'd0, ex});
      chk({tag, "_ty"}, 32'(target_y), {16'd0, ey});
      @(negedge clk);
      chk({tag, "_ik_off"}, 32'(vm_ik_enable), 32'd0);
      chk({tag, "_busy_off"}, 32'(busy), 32'd0);
   endtask

   task automatic run_fault(input string tag, input logic [63:0] mu, input int exp_lat);
      int lat;
      start_eval(mu);
      wait_evt(lat);
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_fault"}, 32'(vm_fault), 32'd1);
      chk({tag, "_no_ik"}, 32'(vm_ik_enable), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic clr_fault();
      @(negedge clk);
      fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;
      chk("fault_cleared", 32'(vm_fault), 32'd0);
   endtask

   initial begin
      int lat;
      rst_n = 1'b0; safety_tier = 2'd0; data_valid = 1'b0; mu_in = '0;
      prog_we = 1'b0; prog_addr = '0; prog_wdata = '0; fault_clr = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_tx", 32'(target_x), 32'd0);
      chk("rst_ty", 32'(target_y), 32'd0);
      chk("rst_outs", {25'd0, vm_ik_enable, vm_vns_override, busy, vm_abort, vm_fault, overrun, prog_err}, 32'd0);
      rst_n = 1'b1;

      // Threshold policy
      wr(8'd0,  ins(4'h1, 4'd0, 16'd1000));
      wr(8'd1,  ins(4'h3, 4'd0, 16'd10));
      wr(8'd2,  ins(4'h4, 4'd0, 16'd20));
      wr(8'd3,  ins(4'h5, 4'd0, 16'd50));
      wr(8'd4,  ins(4'hE, 4'd0, 16'd0));
      wr(8'd10, ins(4'h4, 4'd0, 16'd120));
      wr(8'd11, ins(4'h5, 4'd0, 16'd120));
      wr(8'd12, ins(4'hE, 4'd0, 16'd0));

      run("gt1500", mu_ch0(16'd1500), 5, 16'd120, 16'd120);
      run("eq1000", mu_ch0(16'd1000), 5, 16'd20,  16'd50);
      run("gt1001", mu_ch0(16'd1001), 5, 16'd120, 16'd120);
      run("neg5",   mu_ch0(16'hFFFB), 5, 16'd20,  16'd50);

      // Safety abort two edges into a run
      start_eval(mu_ch0(16'd1500));
      @(negedge clk);
      safety_tier = 2'd2;
      @(negedge clk);
      chk("abort_pulse", 32'(vm_abort), 32'd1);
      chk("abort_no_ik", 32'(vm_ik_enable), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_tx", 32'(target_x), 32'd20);
      chk("abort_ty", 32'(target_y), 32'd50);
      @(negedge clk);
      chk("abort_pulse_end", 32'(vm_abort), 32'd0);
      // Start blocked while tier is high
      data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
      chk("tier_block_busy", 32'(busy), 32'd0);
      chk("tier_block_ovr", 32'(overrun), 32'd0);
      safety_tier = 2'd0;

      // Watchdog on an endless loop
      wr(8'd0, ins(4'h7, 4'd0, 16'd0));
      run_fault("wdog", mu_ch0(16'd0), 128);
      @(negedge clk);
      data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
      chk("fault_start_ignored", 32'(busy), 32'd0);
      chk("fault_start_no_ovr", 32'(overrun), 32'd0);
      chk("fault_sticky", 32'(vm_fault), 32'd1);
      fault_clr = 1'b1; data_valid = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0; data_valid = 1'b0;
      chk("clr_wins_fault", 32'(vm_fault), 32'd0);
      chk("clr_wins_busy", 32'(busy), 32'd0);
      wr(8'd0, ins(4'h1, 4'd0, 16'd1000));
      run("post_clr", mu_ch0(16'd1500), 5, 16'd120, 16'd120);

      // Illegal opcode and out-of-range channel
      wr(8'd0, 32'h9000_0000);
      run_fault("ill_op", mu_ch0(16'd0), 1);
      clr_fault();
      wr(8'd0, ins(4'h1, 4'd4, 16'd0));
      run_fault("ill_ch", mu_ch0(16'd0), 1);
      clr_fault();
      wr(8'd0, ins(4'h1, 4'd0, 16'd1000));
      run("restore", mu_ch0(16'hFFFB), 5, 16'd20, 16'd50);

      // Overrun, rejected write and snapshot isolation mid-run
      start_eval(mu_ch0(16'd1500));
      @(negedge clk);
      data_valid = 1'b1; prog_we = 1'b1; prog_addr = 8'd11;
      prog_wdata = ins(4'h5, 4'd0, 16'd99); mu_in = mu_ch0(16'hFFFB);
      @(negedge clk);
      data_valid = 1'b0; prog_we = 1'b0;
      chk("ovr_pulse", 32'(overrun), 32'd1);
      chk("perr_pulse", 32'(prog_err), 32'd1);
      @(negedge clk);
      chk("ovr_end", 32'(overrun), 32'd0);
      chk("perr_end", 32'(prog_err), 32'd0);
      @(negedge clk);
      chk("ovr_ik_early", 32'(vm_ik_enable), 32'd0);
      @(negedge clk);
      chk("ovr_ik", 32'(vm_ik_enable), 32'd1);
      chk("ovr_tx", 32'(target_x), 32'd120);
      chk("ovr_ty", 32'(target_y), 32'd120);

      // VNS trigger with equal-branch to HALT
      wr(8'd0, ins(4'hF, 4'd0, 16'd0));
      wr(8'd1, ins(4'h1, 4'd3, 16'd0));
      wr(8'd2, ins(4'h6, 4'd0, 16'd4));
      wr(8'd3, ins(4'h4, 4'd0, 16'd7));
      wr(8'd4, ins(4'hE, 4'd0, 16'd0));
      run("vns", 64'd0, 4, 16'd120, 16'd120);
      chk("vns_hold", 32'(vm_vns_override), 32'd1);
      repeat (3) @(negedge clk);
      chk("vns_hold_idle", 32'(vm_vns_override), 32'd1);
      start_eval({16'd5, 48'd0});
      chk("vns_clr_start", 32'(vm_vns_override), 32'd0);
      wait_evt(lat);
      chk("vns2_lat", 32'(lat), 32'd5);
      chk("vns2_tx", 32'(target_x), 32'd7);
      chk("vns2_vns", 32'(vm_vns_override), 32'd1);

      // Program-counter wrap from the last word back to 0
      wr(8'd0,   ins(4'h6, 4'd0, 16'd5));
      wr(8'd1,   ins(4'h7, 4'd0, 16'd254));
      wr(8'd254, ins(4'h1, 4'd0, 16'd0));
      wr(8'd255, ins(4'h4, 4'd0, 16'd33));
      wr(8'd5,   ins(4'hE, 4'd0, 16'd0));
      run("wrap", 64'd0, 6, 16'd33, 16'd120);

      // Reset mid-run returns to reset values; program survives
      start_eval(64'd0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_tx", 32'(target_x), 32'd0);
      chk("mid_rst_outs", {27'd0, vm_ik_enable, vm_vns_override, vm_abort, vm_fault, overrun}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run("after_rst", 64'd0, 6, 16'd33, 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/boreal_policy_vm.md
# boreal_policy_vm

Parametrised, multi-channel successor to the Layer 3 decision engine. It executes a runtime-loadable micro-ISA policy over a snapshot of NCH inference channels and produces Cartesian IK targets plus a VNS override. Over the single-channel fixed-ROM engine it adds:
- atomic target commit;
- mid-run safety abort;
- a step watchdog and illegal-instruction fault;
- input overrun reporting.

It sits between the Apex Core outputs and the CORDIC IK / VNS controllers.

## Interface
- DATA_W, 16: channel and target width, legal range 8..16.
- NCH, 4: inference channels, legal range 1..16.
- PROG_DEPTH, 256: program words (power of 2, ≤65536); ADDR_W = clog2(PROG_DEPTH).
- STEP_LIMIT, 128: maximum instructions per evaluation before watchdog fault.

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- safety_tier  in  2  0..3; tier ≥2 blocks starts and aborts execution
- data_valid  in  1  start strobe for one evaluation
- mu_in  in  NCH*DATA_W  signed channels; ch k = bits [k*DATA_W +: DATA_W]
- prog_we  in  1  program write strobe
- prog_addr  in  ADDR_W  write address
- prog_wdata  in  32  instruction word
- fault_clr  in  1  clears sticky vm_fault
- target_x, target_y  out  DATA_W  signed committed targets
- vm_ik_enable  out  1  1-cycle commit strobe to IK
- vm_vns_override  out  1  VNS override level
- busy  out  1  high in EXEC and DONE
- vm_abort  out  1  1-cycle pulse on safety abort
- vm_fault  out  1  sticky watchdog/illegal fault
- overrun  out  1  1-cycle pulse: data_valid dropped
- prog_err  out  1  1-cycle pulse: prog_we rejected

## Operation

**Instruction word**
- [31:28] opcode; [27:24] channel; [15:0] imm.
- imm: low DATA_W bits, signed.
- Jump target: [ADDR_W-1:0].

**Opcodes**
- 0 NOP.
- 1 CMP: compare snapshot[ch] with imm, signed; set flags lt/gt/eq.
- 2 JLT, 3 JGT, 6 JEQ: jump if the flag is set, else pc+1.
- 7 JMP: unconditional jump.
- 4 SET_X / 5 SET_Y: write the shadow X / shadow Y register.
- F VNS_TRIG: set vm_vns_override.
- E HALT: commit.
- Any other opcode, or CMP with ch ≥ NCH, is illegal → fault.

**States**
- IDLE → EXEC on data_valid when tier<2 and !vm_fault.
  - On start: snapshot all channels, pc=0, flags=0, shadows=current targets, steps=0, vm_vns_override=0.
  - data_valid with tier ≥2 or vm_fault set: ignored, no overrun pulse.
- EXEC executes one instruction per cycle; steps increments per instruction.
  - HALT: target_x/target_y ← shadows, vm_ik_enable=1 for one cycle, go to DONE.
  - safety_tier[1]=1: takes priority over the current instruction. Go to IDLE, vm_abort pulse, shadows discarded, targets unchanged, vm_vns_override=0.
  - Illegal instruction, or steps reaching STEP_LIMIT with no HALT: go to IDLE, vm_fault=1, targets unchanged, vm_vns_override=0.
- DONE → IDLE after one cycle. vm_vns_override holds until the next start.

**Boundary behaviour**
- pc+1 wraps PROG_DEPTH-1 → 0.
- Snapshot isolates the evaluation from mu_in changes after the start cycle.
- data_valid while busy: dropped, overrun pulse.
- prog_we while idle: writes the word. prog_we while busy: rejected, prog_err pulse.
- Program memory is not reset; it powers up as NOP.
- vm_fault clears on fault_clr, which is honoured only in IDLE.
  - fault_clr together with data_valid: the clear applies, the start is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, flags 0, shadows 0. Program memory is untouched.
- Start accepted at edge E0. The instruction at pc=0 executes in the cycle after E0.
- An evaluation of N instructions, HALT included, raises vm_ik_enable for the cycle following edge E0+N.
  - busy is high from E0 through E0+N+1.
  - The next start can be accepted at edge E0+N+2.
- Targets change only on the edge that raises vm_ik_enable.
- Reset asserted mid-EXEC: immediate return to reset values. No strobe and no abort pulse.

## Test plan
1. Load policy [CMP ch0,1000; JGT 10; SET_X 20; SET_Y 50; HALT; @10 SET_X 120; SET_Y 120; HALT]. Drive ch0=1500 → ik strobe 5 cycles after start, target=(120,120). Drive ch0=−5 → target=(20,50).
2. Same policy with ch0=1500; at start+2 raise safety_tier=2 → vm_abort pulse, no ik strobe, targets stay (20,50) from the previous run.
3. Program [JMP 0] with STEP_LIMIT=128 → vm_fault=1 after 128 exec cycles, no strobe. Starts ignored until fault_clr; after the clear, a normal start succeeds.
4. Write opcode 0x9 at address 0, and separately CMP with ch=NCH → vm_fault set in the cycle after execution.
5. data_valid and prog_we pulsed during EXEC → one overrun and one prog_err pulse. The program word is unchanged and the run completes normally.
6. Run [VNS_TRIG; CMP ch3,0; JEQ 4; SET_X 7; HALT] with ch3=0 → vm_vns_override=1 through DONE, target_x unchanged, vm_vns_override cleared at the next start.
